// File: rtl/gr_heep_pkg.sv
// rtl/gr_heep_pkg.sv - platform constants and shared copy-engine types
package gr_heep_pkg;

  localparam int unsigned ExtXbarNMaster = 1;
  localparam int unsigned CopyMasterIdx  = ExtXbarNMaster - 1;

  localparam logic [31:0] KeccakStartAddr = 32'hF000_0000;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    DONE
  } copy_state_e;

endpackage

// File: rtl/obi_pkg.sv
// rtl/obi_pkg.sv - OBI request/response bundles shared across the crossbar
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/ext_obi_copy_master.sv
// rtl/ext_obi_copy_master.sv - word-by-word OBI copy initiator, one outstanding transaction
module ext_obi_copy_master
  import obi_pkg::*;
  import gr_heep_pkg::*;
#(
  parameter int LenWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [31:0]         src_addr_i,
  input  logic [31:0]         dst_addr_i,
  input  logic [LenWidth-1:0] len_i,
  input  logic                dst_incr_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [LenWidth-1:0] words_left_o,
  output obi_req_t            master_req_o,
  input  obi_resp_t           master_resp_i
);

  copy_state_e         state, stateNext;
  logic [31:0]         srcPtr, dstPtr, dataReg;
  logic [LenWidth-1:0] count;
  logic                dstIncr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      srcPtr  <= '0;
      dstPtr  <= '0;
      dataReg <= '0;
      count   <= '0;
      dstIncr <= 1'b0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (start_i) begin
            srcPtr  <= src_addr_i & ~32'h3;
            dstPtr  <= dst_addr_i & ~32'h3;
            count   <= len_i;
            dstIncr <= dst_incr_i;
          end
        end
        RD_WAIT: begin
          if (master_resp_i.rvalid) dataReg <= master_resp_i.rdata;
        end
        WR_WAIT: begin
          // A word counts as moved only once its write has been acknowledged.
          if (master_resp_i.rvalid) begin
            count  <= count - LenWidth'(1);
            srcPtr <= srcPtr + 32'd4;
            dstPtr <= dstPtr + (dstIncr ? 32'd4 : 32'd0);
          end
        end
        default: ;
      endcase
    end
  end

  // Request fields depend only on registered state, never on the response.
  always_comb begin
    stateNext    = state;
    master_req_o = '0;
    case (state)
      IDLE: begin
        if (start_i) stateNext = (len_i == '0) ? DONE : RD_REQ;
      end
      RD_REQ: begin
        master_req_o.req  = 1'b1;
        master_req_o.be   = 4'hF;
        master_req_o.addr = srcPtr;
        if (master_resp_i.gnt) stateNext = RD_WAIT;
      end
      RD_WAIT: begin
        if (master_resp_i.rvalid) stateNext = WR_REQ;
      end
      WR_REQ: begin
        master_req_o.req   = 1'b1;
        master_req_o.we    = 1'b1;
        master_req_o.be    = 4'hF;
        master_req_o.addr  = dstPtr;
        master_req_o.wdata = dataReg;
        if (master_resp_i.gnt) stateNext = WR_WAIT;
      end
      WR_WAIT: begin
        if (master_resp_i.rvalid) stateNext = (count > LenWidth'(1)) ? RD_REQ : DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign busy_o       = (state != IDLE);
  assign done_o       = (state == DONE);
  assign words_left_o = count;

endmodule

// File: tb/tb_ext_obi_copy_master.sv
// tb/tb_ext_obi_copy_master.sv - randomized bench with OBI memory model and transfer scoreboard
module tb_ext_obi_copy_master;
  import obi_pkg::*;
  import gr_heep_pkg::KeccakStartAddr;

  localparam int LenWidth = 16;

  logic                clk = 1'b0;
  logic                rst, start, dstIncr;
  logic [31:0]         srcAddr, dstAddr;
  logic [LenWidth-1:0] len;
  logic                busy, done;
  logic [LenWidth-1:0] wordsLeft;
  obi_req_t            req;
  obi_resp_t           resp;

  always #5 clk = ~clk;

  ext_obi_copy_master #(.LenWidth(LenWidth)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .src_addr_i   (srcAddr),
    .dst_addr_i   (dstAddr),
    .len_i        (len),
    .dst_incr_i   (dstIncr),
    .busy_o       (busy),
    .done_o       (done),
    .words_left_o (wordsLeft),
    .master_req_o (req),
    .master_resp_i(resp)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] memFn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        expQ[$];
  logic [31:0] grantLog[$];

  bit          mBusy = 0, mDoneNow = 0;
  int          mLeft = 0;
  int          cyc = 0, startCyc = 0, doneCyc = 0, doneCount = 0, busyCycles = 0;
  bit          randMode = 0;
  bit          prevStall = 0, rvPending = 0, rvIsWrite = 0, rvNow = 0, rvWasWrite = 0;
  int          gntWait = 0, rvCnt = 0;
  logic [31:0] rvData;
  obi_req_t    reqHold;
  txn_t        e;

  // Memory slave plus cycle-level expectations, all evaluated mid-cycle.
  initial begin
    resp = '0;
    forever begin
      @(negedge clk);
      cyc++;
      resp  = '0;
      rvNow = 0;
      if (rvPending) begin
        rvCnt--;
        if (rvCnt == 0) begin
          rvPending   = 0;
          resp.rvalid = 1'b1;
          resp.rdata  = rvData;
          rvNow       = 1;
          rvWasWrite  = rvIsWrite;
        end
      end

      chk("busy", busy, mBusy);
      chk("done", done, mDoneNow);
      chk("words_left", wordsLeft, LenWidth'(mLeft));
      if (!mBusy || mDoneNow) chk("req_quiet", req == '0, 1);
      if (prevStall) begin
        chk("req_held", req.req, 1);
        chk("req_stable", req == reqHold, 1);
      end
      if (done) begin doneCount++; doneCyc = cyc; end
      if (busy) busyCycles++;

      if (req.req) begin
        chk("one_outstanding", rvPending || rvNow, 0);
        if (!prevStall) begin
          reqHold = req;
          gntWait = randMode ? int'($urandom_range(0, 5)) : 0;
        end
        if (gntWait == 0) begin
          resp.gnt  = 1'b1;
          prevStall = 0;
          grantLog.push_back(req.addr);
          chk("be", req.be, 4'hF);
          if (expQ.size() == 0) chk("unexpected_txn", 1, 0);
          else begin
            e = expQ.pop_front();
            chk("txn_we", req.we, e.we);
            chk("txn_addr", req.addr, e.addr);
            if (e.we) chk("txn_wdata", req.wdata, e.wdata);
          end
          rvPending = 1;
          rvCnt     = randMode ? int'($urandom_range(1, 5)) : 1;
          rvIsWrite = req.we;
          rvData    = req.we ? $urandom : memFn(req.addr);
        end else begin
          gntWait--;
          prevStall = 1;
        end
      end else prevStall = 0;

      if (mDoneNow) begin
        chk("all_txns_done", expQ.size(), 0);
        mBusy    = 0;
        mDoneNow = 0;
      end else if (!mBusy && start) begin
        mBusy    = 1;
        mLeft    = int'(len);
        startCyc = cyc;
        for (int i = 0; i < int'(len); i++) begin
          logic [31:0] s;
          s = (srcAddr & ~32'h3) + 32'(4 * i);
          expQ.push_back('{we: 1'b0, addr: s, wdata: 32'h0});
          expQ.push_back('{we: 1'b1, addr: (dstAddr & ~32'h3) + (dstIncr ? 32'(4 * i) : 32'h0),
                           wdata: memFn(s)});
        end
        if (len == '0) mDoneNow = 1;
      end else if (mBusy && rvNow && rvWasWrite) begin
        mLeft--;
        if (mLeft == 0) mDoneNow = 1;
      end

      if (rst) begin
        mBusy = 0; mDoneNow = 0; mLeft = 0;
        expQ.delete();
        rvPending = 0; prevStall = 0;
      end
    end
  end

  task automatic waitDone(input int d0);
    int n = 0;
    while (doneCount == d0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("done_timeout", doneCount == d0, 0);
    @(posedge clk); #2;
  endtask

  task automatic runXfer(input logic [31:0] s, input logic [31:0] d, input int n,
                         input bit inc, input int extraAt);
    int d0;
    grantLog.delete();
    busyCycles = 0;
    d0 = doneCount;
    @(posedge clk); #2;
    srcAddr = s; dstAddr = d; len = LenWidth'(n); dstIncr = inc; start = 1;
    @(posedge clk); #2;
    start = 0;
    srcAddr = $urandom; dstAddr = $urandom; len = LenWidth'($urandom_range(1, 9)); dstIncr = ~inc;
    if (extraAt > 0) begin
      repeat (extraAt) @(posedge clk);
      #2 start = 1;
      @(posedge clk); #2 start = 0;
    end
    waitDone(d0);
  endtask

  initial begin
    int n;
    rst = 1; start = 0; srcAddr = '0; dstAddr = '0; len = '0; dstIncr = 0;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_words_left", wordsLeft, 0);
    chk("rst_req", req == '0, 1);

    runXfer(32'h0000_1000, KeccakStartAddr, 3, 1, 0);
    chk("t1_latency", doneCyc - startCyc, 13);
    chk("t1_count", grantLog.size(), 6);
    if (grantLog.size() == 6) begin
      chk("t1_rd0", grantLog[0], 32'h0000_1000);
      chk("t1_wr0", grantLog[1], 32'hF000_0000);
      chk("t1_rd1", grantLog[2], 32'h0000_1004);
      chk("t1_wr1", grantLog[3], 32'hF000_0004);
      chk("t1_rd2", grantLog[4], 32'h0000_1008);
      chk("t1_wr2", grantLog[5], 32'hF000_0008);
    end

    runXfer(32'h0000_2003, 32'h0000_8002, 4, 0, 0);
    chk("t2_count", grantLog.size(), 8);
    if (grantLog.size() == 8)
      for (int i = 0; i < 4; i++) chk("t2_fixed_dst", grantLog[2 * i + 1], 32'h0000_8000);

    randMode = 1;
    runXfer($urandom, $urandom, 8, 1, 0);
    chk("t3_words_left_end", wordsLeft, 0);
    for (int k = 0; k < 4; k++) runXfer($urandom, $urandom, $urandom_range(1, 8), 1'($urandom), 0);
    randMode = 0;

    runXfer(32'h0000_3000, 32'h0000_4000, 0, 1, 0);
    chk("t4_latency", doneCyc - startCyc, 1);
    chk("t4_busy_cycles", busyCycles, 1);
    chk("t4_no_req", grantLog.size(), 0);

    runXfer(32'hFFFF_FFF8, 32'h0000_5000, 3, 1, 0);
    chk("t5_count", grantLog.size(), 6);
    if (grantLog.size() == 6) begin
      chk("t5_rd0", grantLog[0], 32'hFFFF_FFF8);
      chk("t5_rd1", grantLog[2], 32'hFFFF_FFFC);
      chk("t5_rd2", grantLog[4], 32'h0000_0000);
    end

    runXfer(32'h0000_6000, 32'h0000_7000, 4, 1, 3);
    chk("t6_ignored_start", grantLog.size(), 8);
    chk("t6_latency", doneCyc - startCyc, 17);

    @(posedge clk); #2;
    srcAddr = 32'h0000_9000; dstAddr = KeccakStartAddr; len = 3; dstIncr = 1; start = 1;
    @(posedge clk); #2 start = 0;
    n = 0;
    while (!(req.req && req.we) && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    chk("t7_reach_wr_req", n < 100, 1);
    rst = 1;
    @(posedge clk); #2 rst = 0;
    chk("t7_busy", busy, 0);
    chk("t7_done", done, 0);
    chk("t7_words_left", wordsLeft, 0);
    chk("t7_req", req == '0, 1);
    runXfer(32'h0000_A000, 32'h0000_B000, 2, 1, 0);
    chk("t7_after_latency", doneCyc - startCyc, 9);
    chk("t7_after_count", grantLog.size(), 4);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
